// File: rtl/aes_pkg.sv
// Shared AES datapath types and widths.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_STATE_W = 5;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

endpackage

// File: rtl/aes_block_fifo_if.sv
// Bus-side write and pipeline-side read handshake of the AES input FIFO.
// Optional overflow signals exist only with AES_FIFO_OVERFLOW_DETECT_EN.
interface aes_block_fifo_if
  import aes_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = AES_BLOCK_W
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             i_wr_en;
  logic [WIDTH-1:0] i_wr_data;
  logic             o_full;
  logic             o_empty;
  logic [CNT_W-1:0] o_count;
  logic             i_slot_free;
  logic             o_read_fifo;
  logic [WIDTH-1:0] o_fifo_data;
`ifdef AES_FIFO_OVERFLOW_DETECT_EN
  logic             o_overflow;
  logic             i_clear_err;
`endif

  modport master (
    output i_wr_en, i_wr_data, i_slot_free,
`ifdef AES_FIFO_OVERFLOW_DETECT_EN
    output i_clear_err,
    input  o_overflow,
`endif
    input  o_full, o_empty, o_count, o_read_fifo, o_fifo_data
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_slot_free,
`ifdef AES_FIFO_OVERFLOW_DETECT_EN
    input  i_clear_err,
    output o_overflow,
`endif
    output o_full, o_empty, o_count, o_read_fifo, o_fifo_data
  );

endinterface

// File: rtl/aes_fifo_ptr.sv
// Read/write pointer and occupancy tracking for the AES block FIFO.
module aes_fifo_ptr #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       push,
  input  logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/aes_block_fifo.sv
// First-word-fall-through input buffer feeding data block select in the AES round pipeline.
// Optional sticky overflow flag enabled by AES_FIFO_OVERFLOW_DETECT_EN.
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = AES_BLOCK_W
) (
  input logic              i_clk,
  input logic              i_rst,
  aes_block_fifo_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop  = bus.i_slot_free & ~empty;
  assign push = bus.i_wr_en & (~full | pop);

  aes_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .push   (push),
    .pop    (pop),
    .rd_ptr (rd_ptr),
    .wr_ptr (wr_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Storage is intentionally not reset; contents are don't-care while empty.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= bus.i_wr_data;
  end

  assign bus.o_read_fifo = pop;
  assign bus.o_fifo_data = mem[rd_ptr];
  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_count     = count;

`ifdef AES_FIFO_OVERFLOW_DETECT_EN
  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                               bus.o_overflow <= 1'b0;
    else if (bus.i_wr_en && full && !pop)    bus.o_overflow <= 1'b1;
    else if (bus.i_clear_err)                bus.o_overflow <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_aes_block_fifo.sv
// Randomized self-checking bench for aes_block_fifo against a queue-based model.
module tb_aes_block_fifo;
  import aes_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = AES_BLOCK_W;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_block_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  aes_block_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  aes_block_t q[$];
  bit         exp_pop;
  aes_block_t exp_head;
  bit         ovf_m = 1'b0;

  function automatic aes_block_t rnd_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Apply inputs just after the falling edge and derive expected combinational outputs.
  task automatic drive(input bit wr, input aes_block_t data, input bit sf, input bit clr = 1'b0);
    bus.i_wr_en     = wr;
    bus.i_wr_data   = data;
    bus.i_slot_free = sf;
`ifdef AES_FIFO_OVERFLOW_DETECT_EN
    bus.i_clear_err = clr;
`else
    if (clr) exp_pop = exp_pop;
`endif
    #1;
    exp_pop  = sf && (q.size() != 0);
    exp_head = (q.size() != 0) ? q[0] : '0;
  endtask

  // Advance the reference model by one clock edge, then move to the next falling edge.
  task automatic tick();
    bit pop_m, push_m;
    pop_m  = bus.i_slot_free && (q.size() != 0);
    push_m = bus.i_wr_en && ((q.size() < DEPTH) || pop_m);
    if (bus.i_wr_en && (q.size() == DEPTH) && !pop_m) ovf_m = 1'b1;
`ifdef AES_FIFO_OVERFLOW_DETECT_EN
    else if (bus.i_clear_err) ovf_m = 1'b0;
`endif
    if (pop_m)  void'(q.pop_front());
    if (push_m) q.push_back(bus.i_wr_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b1);
    n_checks++; if (bus.o_empty !== 1'b1) $display("FAIL reset_empty: got %0b want 1", bus.o_empty); else n_pass++;
    n_checks++; if (bus.o_full !== 1'b0) $display("FAIL reset_full: got %0b want 0", bus.o_full); else n_pass++;
    n_checks++; if (bus.o_count !== CNT_W'(0)) $display("FAIL reset_count: got %0d want 0", bus.o_count); else n_pass++;
    n_checks++; if (bus.o_read_fifo !== 1'b0) $display("FAIL reset_read: got %0b want 0", bus.o_read_fifo); else n_pass++;
`ifdef AES_FIFO_OVERFLOW_DETECT_EN
    n_checks++; if (bus.o_overflow !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", bus.o_overflow); else n_pass++;
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1);
      n_checks++;
      if (bus.o_read_fifo !== 1'b0 || bus.o_empty !== 1'b1 || bus.o_count !== CNT_W'(0))
        $display("FAIL idle_%0d: read=%0b empty=%0b count=%0d want 0/1/0", i, bus.o_read_fifo, bus.o_empty, bus.o_count);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_single();
    aes_block_t blk = 128'h000102030405060708090a0b0c0d0e0f;
    drive(1'b1, blk, 1'b1);
    n_checks++; if (bus.o_read_fifo !== 1'b0) $display("FAIL single_no_bypass: got %0b want 0", bus.o_read_fifo); else n_pass++;
    tick();
    drive(1'b0, '0, 1'b1);
    n_checks++; if (bus.o_read_fifo !== 1'b1) $display("FAIL single_strobe: got %0b want 1", bus.o_read_fifo); else n_pass++;
    n_checks++; if (bus.o_fifo_data !== blk) $display("FAIL single_data: got %h want %h", bus.o_fifo_data, blk); else n_pass++;
    tick();
    drive(1'b0, '0, 1'b1);
    n_checks++; if (bus.o_empty !== 1'b1 || bus.o_read_fifo !== 1'b0) $display("FAIL single_drained: empty=%0b read=%0b want 1/0", bus.o_empty, bus.o_read_fifo); else n_pass++;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 128'(i), 1'b0);
      tick();
    end
    drive(1'b1, 128'(99), 1'b0);
    n_checks++; if (bus.o_full !== 1'b1 || bus.o_count !== CNT_W'(8)) $display("FAIL fill_full: full=%0b count=%0d want 1/8", bus.o_full, bus.o_count); else n_pass++;
    tick();
    drive(1'b0, '0, 1'b0);
    n_checks++; if (bus.o_count !== CNT_W'(8) || bus.o_fifo_data !== 128'(1)) $display("FAIL fill_drop: count=%0d head=%0d want 8/1", bus.o_count, bus.o_fifo_data); else n_pass++;
`ifdef AES_FIFO_OVERFLOW_DETECT_EN
    n_checks++; if (bus.o_overflow !== 1'b1) $display("FAIL fill_ovf_set: got %0b want 1", bus.o_overflow); else n_pass++;
    drive(1'b1, 128'(77), 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    n_checks++; if (bus.o_overflow !== 1'b1) $display("FAIL ovf_set_wins: got %0b want 1", bus.o_overflow); else n_pass++;
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    n_checks++; if (bus.o_overflow !== 1'b0) $display("FAIL ovf_clear: got %0b want 0", bus.o_overflow); else n_pass++;
`endif
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, '0, 1'b1);
      n_checks++;
      if (bus.o_read_fifo !== 1'b1 || bus.o_fifo_data !== 128'(i))
        $display("FAIL drain_%0d: read=%0b data=%0d want 1/%0d", i, bus.o_read_fifo, bus.o_fifo_data, i);
      else n_pass++;
      tick();
    end
    drive(1'b0, '0, 1'b1);
    n_checks++; if (bus.o_empty !== 1'b1) $display("FAIL drain_empty: got %0b want 1", bus.o_empty); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 128'(i), 1'b0);
      tick();
    end
    drive(1'b1, 128'(9), 1'b1);
    n_checks++; if (bus.o_read_fifo !== 1'b1 || bus.o_fifo_data !== 128'(1)) $display("FAIL fullpp_pop: read=%0b data=%0d want 1/1", bus.o_read_fifo, bus.o_fifo_data); else n_pass++;
    tick();
    drive(1'b0, '0, 1'b0);
    n_checks++; if (bus.o_count !== CNT_W'(8) || bus.o_full !== 1'b1) $display("FAIL fullpp_count: count=%0d full=%0b want 8/1", bus.o_count, bus.o_full); else n_pass++;
    for (int i = 2; i <= 9; i++) begin
      drive(1'b0, '0, 1'b1);
      n_checks++;
      if (bus.o_read_fifo !== 1'b1 || bus.o_fifo_data !== 128'(i))
        $display("FAIL fullpp_drain_%0d: read=%0b data=%0d want 1/%0d", i, bus.o_read_fifo, bus.o_fifo_data, i);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_wrap();
    int  sent = 100;
    int  got  = 0;
    int  cyc  = 0;
    bit  wr, sf;
    while (got < 20 && cyc < 200) begin
      wr = (sent < 120) && (q.size() < 3);
      sf = (q.size() >= 2) || (q.size() == 1 && (sent == 120 || $urandom_range(0, 1) == 1));
      drive(wr, 128'(sent), sf);
      n_checks++;
      if (bus.o_read_fifo !== exp_pop) $display("FAIL wrap_strobe_c%0d: got %0b want %0b", cyc, bus.o_read_fifo, exp_pop);
      else n_pass++;
      if (exp_pop) begin
        n_checks++;
        if (bus.o_fifo_data !== 128'(100 + got)) $display("FAIL wrap_order_%0d: got %0d want %0d", got, bus.o_fifo_data, 100 + got);
        else n_pass++;
        got++;
      end
      if (wr) sent++;
      tick();
      cyc++;
    end
    n_checks++; if (got != 20) $display("FAIL wrap_timeout: delivered %0d want 20", got); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 99) < 60, rnd_block(), $urandom_range(0, 99) < 45, $urandom_range(0, 19) == 0);
      n_checks++;
      if (bus.o_read_fifo !== exp_pop || bus.o_count !== CNT_W'(q.size()) ||
          bus.o_full !== (q.size() == DEPTH) || bus.o_empty !== (q.size() == 0))
        $display("FAIL rand_ctrl_c%0d: read=%0b count=%0d full=%0b empty=%0b want %0b/%0d", c,
                 bus.o_read_fifo, bus.o_count, bus.o_full, bus.o_empty, exp_pop, q.size());
      else n_pass++;
      if (q.size() != 0) begin
        n_checks++;
        if (bus.o_fifo_data !== exp_head) $display("FAIL rand_data_c%0d: got %h want %h", c, bus.o_fifo_data, exp_head);
        else n_pass++;
      end
`ifdef AES_FIFO_OVERFLOW_DETECT_EN
      n_checks++;
      if (bus.o_overflow !== ovf_m) $display("FAIL rand_ovf_c%0d: got %0b want %0b", c, bus.o_overflow, ovf_m);
      else n_pass++;
`endif
      tick();
    end
  endtask

  task automatic test_reset_mid();
    aes_block_t aa = {16{8'hAA}};
    while (q.size() != 0) begin
      drive(1'b0, '0, 1'b1);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, rnd_block(), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    n_checks++; if (bus.o_count !== CNT_W'(5)) $display("FAIL midrst_pre_count: got %0d want 5", bus.o_count); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.o_empty !== 1'b1 || bus.o_count !== CNT_W'(0) || bus.o_read_fifo !== 1'b0)
      $display("FAIL midrst_async: empty=%0b count=%0d read=%0b want 1/0/0", bus.o_empty, bus.o_count, bus.o_read_fifo);
    else n_pass++;
    q.delete();
    ovf_m = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, aa, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1);
    n_checks++;
    if (bus.o_read_fifo !== 1'b1 || bus.o_fifo_data !== aa)
      $display("FAIL midrst_first: read=%0b data=%h want 1/%h", bus.o_read_fifo, bus.o_fifo_data, aa);
    else n_pass++;
    tick();
    drive(1'b0, '0, 1'b1);
    n_checks++; if (bus.o_empty !== 1'b1) $display("FAIL midrst_empty: got %0b want 1", bus.o_empty); else n_pass++;
  endtask

  initial begin
    bus.i_wr_en     = 1'b0;
    bus.i_wr_data   = '0;
    bus.i_slot_free = 1'b0;
`ifdef AES_FIFO_OVERFLOW_DETECT_EN
    bus.i_clear_err = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_single();
    tick();
    test_fill_drain();
    test_full_push_pop();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
